imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Shares the single-port instruction memory between the core's fetch stage (port F) and the debug/boot loader (port L). Each cycle it grants at most one request, drives the IMEM array's synchronous port, and returns the response to the granted requester one cycle later. Fetch has priority, bounded by a starvation limit, and the loader can lock fetch out entirely during program load.

## Interface
Parameters:
- `STARVE_LIMIT`, default 8: maximum consecutive fetch grants while L is pending before L is forced through. Legal range 1..255.
- `DEPTH_WORDS`, default 256: IMEM depth in 32-bit words, matching the 1 KiB DMEM size.

Ports (all `u32_t` from `types`):
- `clk`  in  1  clock. Everything is rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `f_req`  in  1  fetch read request.
- `f_addr`  in  32  fetch byte address.
- `f_gnt`  out  1  fetch request accepted this cycle.
- `f_rvalid`  out  1  fetch response valid.
- `f_rdata`  out  32  fetch read data.
- `f_err`  out  1  fetch response is an error (range or alignment).
- `l_req`  in  1  loader request.
- `l_we`  in  1  loader write (1) or read (0).
- `l_addr`  in  32  loader byte address.
- `l_wdata`  in  32  loader write data.
- `l_lock`  in  1  loader owns IMEM; fetch is never granted.
- `l_gnt`  out  1  loader request accepted this cycle.
- `l_rvalid`  out  1  loader response valid.
- `l_rdata`  out  32  loader read data; 0 for writes.
- `l_err`  out  1  loader response is an error.
- `mem_en`  out  1  array access enable.
- `mem_we`  out  1  array write enable.
- `mem_idx`  out  $clog2(DEPTH_WORDS)  word index, `addr[9:2]` at defaults.
- `mem_wdata`  out  32  array write data.
- `mem_rdata`  in  32  array read data, valid the cycle after `mem_en`.

## Operation
- Grant rule: the port sets its `gnt` combinationally in the same cycle as its `req`.
  - Default priority is F.
  - L wins if `l_lock`=1, or if `starve_cnt` = `STARVE_LIMIT` and L is requesting.
  - Exactly one of `f_gnt`/`l_gnt` is high when any eligible request exists. Both are 0 otherwise.
- `starve_cnt`:
  - Increments on each F grant while `l_req`=1, saturating at `STARVE_LIMIT`.
  - Clears on any L grant, or in any cycle with `l_req`=0.
- Address check at grant:
  - Error if `addr[1:0]`≠0 or `addr` ≥ 4·`DEPTH_WORDS`.
  - An erroring grant does not assert `mem_en` or `mem_we`.
  - Its response has `err`=1 and `rdata`=0.
- A granted valid access drives:
  - `mem_en`=1.
  - `mem_we`=`l_we` for L, 0 for F.
  - `mem_idx` = word index.
  - `mem_wdata`=`l_wdata`.
- Response pipeline is one stage holding {valid, port, err, is_write}. The stage is loaded on every grant and cleared otherwise.
- In the response cycle:
  - `<port>_rvalid`=1.
  - `rdata` = `mem_rdata` for a valid read, 0 for a write or error.
  - Responses have no backpressure; requesters must accept them.
- `l_lock` rising while an F response is in flight: that response still completes normally.
- Reset (synchronous, `rst_n`=0 at a clock edge):
  - All outputs are 0 in that cycle and after the edge: gnts, rvalids, rdatas, errs, `mem_en`, `mem_we`, `mem_idx`, `mem_wdata`.
  - `starve_cnt` is cleared and the response stage is cleared.
  - An in-flight response is dropped.
  - Grants are forced to 0 while `rst_n`=0.

## Timing
- Throughput: one grant per cycle with back-to-back requests, no bubbles.
- Latency: grant in cycle N, `rvalid` in cycle N+1, for both ports and for both reads and writes.
- A write is visible to a read granted in cycle N+1 or later.
- No combinational path from `mem_rdata` to any gnt.

## Structure
- Add to package `types`:
  - `imem_port_e` enum {PORT_F, PORT_L}.
  - `imem_rsp_t` struct {valid, port, err, is_write}.
- Single module, no sub-module: the grant logic and starvation counter are in one `always_comb` and one `always_ff`.

## Test plan
- Fetch-only stream: `f_addr`=0,4,8 with preloaded words A,B,C. Expect `f_gnt`=1 each cycle and `f_rdata`=A,B,C one cycle later.
- Contention, `STARVE_LIMIT`=8: `f_req` and `l_req` held high. Expect 8 F grants, 1 L grant, then repeat. `starve_cnt` returns to 0 after the L grant.
- `l_lock`=1, L writes 0xDEADBEEF to 0x10, then F reads 0x10 after lock release. Expect `f_gnt`=0 throughout the lock and `f_rdata`=0xDEADBEEF.
- F reads 0x3 and 0x400 (`DEPTH_WORDS`=256). Expect `mem_en`=0, `f_err`=1 and `f_rdata`=0 for each.
- `rst_n` dropped the cycle after an L read grant. Expect `l_rvalid`=0, all outputs 0, and a normal F grant on the first cycle after `rst_n` returns to 1.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: port identifiers, the
// response-stage record and the address legality helper.
package types;

  typedef logic [31:0] u32_t;

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_L = 1'b1
  } imem_port_e;

  typedef struct packed {
    logic       valid;
    imem_port_e port;
    logic       err;
    logic       is_write;
  } imem_rsp_t;

  // Starvation counter width; covers the full 1..255 limit range.
  localparam int STARVE_W = 8;

  // Misaligned or out-of-range byte addresses never reach the array.
  function automatic logic addr_bad(input u32_t addr, input u32_t limit);
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/imem_arbiter.sv
// Single-port IMEM arbiter between fetch (F) and debug/boot loader (L):
// fetch-priority grant with starvation bound, loader lock, one-cycle response.
module imem_arbiter
  import types::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int DEPTH_WORDS  = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           f_req,
  input  u32_t                           f_addr,
  output logic                           f_gnt,
  output logic                           f_rvalid,
  output u32_t                           f_rdata,
  output logic                           f_err,
  input  logic                           l_req,
  input  logic                           l_we,
  input  u32_t                           l_addr,
  input  u32_t                           l_wdata,
  input  logic                           l_lock,
  output logic                           l_gnt,
  output logic                           l_rvalid,
  output u32_t                           l_rdata,
  output logic                           l_err,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_idx,
  output u32_t                           mem_wdata,
  input  u32_t                           mem_rdata
);

  localparam int                  IDX_W      = $clog2(DEPTH_WORDS);
  localparam u32_t                ADDR_LIMIT = u32_t'(4 * DEPTH_WORDS);
  localparam logic [STARVE_W-1:0] LIMIT      = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_nxt;
  imem_rsp_t           rsp_q;
  imem_rsp_t           rsp_d;
  logic                grant_f;
  logic                grant_l;
  logic                sel_bad;
  u32_t                sel_addr;
  u32_t                rsp_data;

  // Grant, array drive, next response record and next starvation count.
  // L wins when locked, when F is idle, or once F has used up its budget.
  always_comb begin
    grant_f    = 1'b0;
    grant_l    = 1'b0;
    sel_addr   = '0;
    sel_bad    = 1'b0;
    f_gnt      = 1'b0;
    l_gnt      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_idx    = '0;
    mem_wdata  = '0;
    rsp_d      = '0;
    starve_nxt = starve_cnt;

    if (rst_n) begin
      grant_l = l_req && (l_lock || !f_req || (starve_cnt == LIMIT));
      grant_f = f_req && !l_lock && !grant_l;
    end

    sel_addr = grant_l ? l_addr : f_addr;
    sel_bad  = addr_bad(sel_addr, ADDR_LIMIT);
    f_gnt    = grant_f;
    l_gnt    = grant_l;

    if ((grant_f || grant_l) && !sel_bad) begin
      mem_en    = 1'b1;
      mem_we    = grant_l && l_we;
      mem_idx   = sel_addr[IDX_W+1:2];
      mem_wdata = l_wdata;
    end

    if (grant_f || grant_l) begin
      rsp_d.valid    = 1'b1;
      rsp_d.port     = grant_l ? PORT_L : PORT_F;
      rsp_d.err      = sel_bad;
      rsp_d.is_write = grant_l && l_we;
    end

    if (!l_req || grant_l) begin
      starve_nxt = '0;
    end else if (grant_f && (starve_cnt != LIMIT)) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      rsp_q      <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      rsp_q      <= rsp_d;
    end
  end

  // Route the registered response to its owner; held at zero during reset
  // so a response in flight when reset arrives is dropped.
  always_comb begin
    f_rvalid = 1'b0;
    f_rdata  = '0;
    f_err    = 1'b0;
    l_rvalid = 1'b0;
    l_rdata  = '0;
    l_err    = 1'b0;
    rsp_data = (rsp_q.err || rsp_q.is_write) ? '0 : mem_rdata;

    if (rst_n && rsp_q.valid) begin
      if (rsp_q.port == PORT_F) begin
        f_rvalid = 1'b1;
        f_rdata  = rsp_data;
        f_err    = rsp_q.err;
      end else begin
        l_rvalid = 1'b1;
        l_rdata  = rsp_data;
        l_err    = rsp_q.err;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: cycle-by-cycle vector table against a
// behavioural IMEM, plus hand-written contention/starvation sequences.
module tb_imem_arbiter;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_lock;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic        l_err;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_idx;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] imem [DEPTH];

  int n_vectors;
  int n_miscompares;

  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003;
  localparam logic [31:0] WD = 32'hDEAD_BEEF;

  imem_arbiter #(
    .STARVE_LIMIT(8),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .f_err    (f_err),
    .l_req    (l_req),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_lock   (l_lock),
    .l_gnt    (l_gnt),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata),
    .l_err    (l_err),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_idx  (mem_idx),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port array: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) imem[mem_idx] <= mem_wdata;
      else        mem_rdata     <= imem[mem_idx];
    end
  end

  // flags = {f_gnt, l_gnt, mem_en, mem_we, f_rvalid, f_err, l_rvalid, l_err}
  typedef struct {
    string       name;
    logic        rst_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_lock;
    logic [7:0]  flags;
    logic [31:0] f_rdata;
    logic [31:0] l_rdata;
    logic [7:0]  idx;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input string name, input logic rn, input logic fr,
                              input logic [31:0] fa, input logic lr, input logic lw,
                              input logic [31:0] la, input logic [31:0] lwd,
                              input logic lk, input logic [7:0] fl,
                              input logic [31:0] frd, input logic [31:0] lrd,
                              input logic [7:0] ix, input logic [31:0] wd);
    vec_t v;
    v.name = name; v.rst_n = rn; v.f_req = fr; v.f_addr = fa; v.l_req = lr;
    v.l_we = lw; v.l_addr = la; v.l_wdata = lwd; v.l_lock = lk; v.flags = fl;
    v.f_rdata = frd; v.l_rdata = lrd; v.idx = ix; v.wdata = wd;
    return v;
  endfunction

  task automatic applyStimulus(input logic rn, input logic fr, input logic [31:0] fa,
                               input logic lr, input logic lw, input logic [31:0] la,
                               input logic [31:0] lwd, input logic lk);
    @(negedge clk);
    rst_n   = rn;
    f_req   = fr;
    f_addr  = fa;
    l_req   = lr;
    l_we    = lw;
    l_addr  = la;
    l_wdata = lwd;
    l_lock  = lk;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] flags_act;
    logic [1:0] prev_gnt;
    n_vectors     = 0;
    n_miscompares = 0;
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0;
    l_addr = '0; l_wdata = '0; l_lock = 1'b0;
    for (int i = 0; i < DEPTH; i++) imem[i] = 32'h1000_0000 + i;
    imem[0] = WA; imem[1] = WB; imem[2] = WC; imem[4] = 32'h5555_5555;

    //            name          rn fr fa         lr lw la        lwd          lk flags        frd lrd idx wdata
    vecs[0]  = mk("reset0",     0, 1, 32'h0,     1, 0, 32'h4,    32'h0,       0, 8'b0000_0000, 0,  0,  0, 0);
    vecs[1]  = mk("reset1",     0, 0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 8'b0000_0000, 0,  0,  0, 0);
    vecs[2]  = mk("fetch0",     1, 1, 32'h0,     0, 0, 32'h0,    32'h0,       0, 8'b1010_0000, 0,  0,  0, 0);
    vecs[3]  = mk("fetch4",     1, 1, 32'h4,     0, 0, 32'h0,    32'h0,       0, 8'b1010_1000, WA, 0,  1, 0);
    vecs[4]  = mk("fetch8",     1, 1, 32'h8,     0, 0, 32'h0,    32'h0,       0, 8'b1010_1000, WB, 0,  2, 0);
    vecs[5]  = mk("fetch_rsp",  1, 0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 8'b0000_1000, WC, 0,  0, 0);
    vecs[6]  = mk("f_misalign", 1, 1, 32'h3,     0, 0, 32'h0,    32'h0,       0, 8'b1000_0000, 0,  0,  0, 0);
    vecs[7]  = mk("f_range",    1, 1, 32'h400,   0, 0, 32'h0,    32'h0,       0, 8'b1000_1100, 0,  0,  0, 0);
    vecs[8]  = mk("f_rng_rsp",  1, 0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 8'b0000_1100, 0,  0,  0, 0);
    vecs[9]  = mk("lock_wr",    1, 1, 32'h10,    1, 1, 32'h10,   WD,          1, 8'b0111_0000, 0,  0,  4, WD);
    vecs[10] = mk("lock_hold",  1, 1, 32'h10,    0, 0, 32'h0,    32'h0,       1, 8'b0000_0010, 0,  0,  0, 0);
    vecs[11] = mk("f_after",    1, 1, 32'h10,    0, 0, 32'h0,    32'h0,       0, 8'b1010_0000, 0,  0,  4, 0);
    vecs[12] = mk("f_aft_rsp",  1, 0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 8'b0000_1000, WD, 0,  0, 0);
    vecs[13] = mk("l_read0",    1, 0, 32'h0,     1, 0, 32'h0,    32'h0,       0, 8'b0110_0000, 0,  0,  0, 0);
    vecs[14] = mk("l_rd_rsp",   1, 0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 8'b0000_0010, 0,  WA, 0, 0);
    vecs[15] = mk("l_bad_wr",   1, 0, 32'h0,     1, 1, 32'h2,    32'h5,       0, 8'b0100_0000, 0,  0,  0, 0);
    vecs[16] = mk("l_bad_rsp",  1, 0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 8'b0000_0011, 0,  0,  0, 0);
    vecs[17] = mk("l_read4",    1, 0, 32'h0,     1, 0, 32'h4,    32'h0,       0, 8'b0110_0000, 0,  0,  1, 0);
    vecs[18] = mk("rst_drop",   0, 1, 32'h0,     1, 0, 32'h4,    32'h0,       0, 8'b0000_0000, 0,  0,  0, 0);
    vecs[19] = mk("post_rst",   1, 1, 32'h8,     0, 0, 32'h0,    32'h0,       0, 8'b1010_0000, 0,  0,  2, 0);
    vecs[20] = mk("post_rsp",   1, 0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 8'b0000_1000, WC, 0,  0, 0);
    vecs[21] = mk("f_pre_lock", 1, 1, 32'h4,     0, 0, 32'h0,    32'h0,       0, 8'b1010_0000, 0,  0,  1, 0);
    vecs[22] = mk("lock_rise",  1, 1, 32'h4,     0, 0, 32'h0,    32'h0,       1, 8'b0000_1000, WB, 0,  0, 0);
    vecs[23] = mk("idle",       1, 0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 8'b0000_0000, 0,  0,  0, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].f_req, vecs[i].f_addr, vecs[i].l_req,
                    vecs[i].l_we, vecs[i].l_addr, vecs[i].l_wdata, vecs[i].l_lock);
      flags_act = {f_gnt, l_gnt, mem_en, mem_we, f_rvalid, f_err, l_rvalid, l_err};
      if (vecs[i].flags[5] || !vecs[i].rst_n)
        checkOutput(vecs[i].name,
                    {flags_act, f_rdata, l_rdata, mem_idx, mem_wdata},
                    {vecs[i].flags, vecs[i].f_rdata, vecs[i].l_rdata, vecs[i].idx, vecs[i].wdata});
      else
        checkOutput(vecs[i].name,
                    {flags_act, f_rdata, l_rdata},
                    {vecs[i].flags, vecs[i].f_rdata, vecs[i].l_rdata});
    end

    // Full contention: eight F grants, one forced L grant, repeating.
    $display("[TB] contention");
    prev_gnt = 2'b00;
    for (int i = 0; i < 18; i++) begin
      logic exp_l;
      exp_l = ((i % 9) == 8);
      applyStimulus(1, 1, 32'h0, 1, 0, 32'h4, 32'h0, 0);
      checkOutput($sformatf("contend%0d", i), {f_gnt, l_gnt, f_rvalid, l_rvalid},
                  {!exp_l, exp_l, prev_gnt});
      prev_gnt = {!exp_l, exp_l};
    end
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("contend_tail", {f_gnt, l_gnt, f_rvalid, l_rvalid, l_rdata},
                {1'b0, 1'b0, prev_gnt, WB});

    // A cycle without l_req resets the starvation count mid-run.
    $display("[TB] starvation clear");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 32'h0, 1, 0, 32'h4, 32'h0, 0);
      checkOutput($sformatf("partial%0d", i), {f_gnt, l_gnt}, 2'b10);
    end
    applyStimulus(1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("l_drop", {f_gnt, l_gnt}, 2'b10);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 1, 32'h0, 1, 0, 32'h4, 32'h0, 0);
      checkOutput($sformatf("restart%0d", i), {f_gnt, l_gnt}, (i == 8) ? 2'b01 : 2'b10);
    end
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("restart_rsp", {l_rvalid, l_err, l_rdata}, {1'b1, 1'b0, WB});

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
